// File: rtl/riscv_dcache_ctrl_if.sv
// riscv_dcache_ctrl_if
//   Bundles the CPU data-cache port and the word-wide main-memory port used by
//   riscv_dcache_ctrl.
//   slave  : the cache controller's view (takes CPU requests, drives memory requests)
//   master : the environment's view (the CPU plus the memory system)
// Signals
//   cpu_addr/cpu_re/cpu_we/cpu_din : CPU request, held by the CPU while stall is high
//   cpu_dout/stall                 : load data and CPU freeze
//   mem_req_*                      : valid/ready request channel (we=0 means one-word read)
//   mem_resp_valid/mem_resp_data   : read beats, returned in request order
interface riscv_dcache_ctrl_if;
   logic [31:0] cpu_addr;
   logic        cpu_re;
   logic [3:0]  cpu_we;
   logic [31:0] cpu_din;
   logic [31:0] cpu_dout;
   logic        stall;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [3:0]  mem_req_we;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_data;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;

   modport slave (
      input  cpu_addr, cpu_re, cpu_we, cpu_din, mem_req_ready, mem_resp_valid, mem_resp_data,
      output cpu_dout, stall, mem_req_valid, mem_req_we, mem_req_addr, mem_req_data
   );

   modport master (
      output cpu_addr, cpu_re, cpu_we, cpu_din, mem_req_ready, mem_resp_valid, mem_resp_data,
      input  cpu_dout, stall, mem_req_valid, mem_req_we, mem_req_addr, mem_req_data
   );
endinterface

// File: rtl/riscv_dcache_ctrl.sv
// riscv_dcache_ctrl
//   Direct-mapped, write-through, no-write-allocate data cache controller.
//   A request is latched in IDLE and the tag compare happens in CMP on the
//   latched copy. Load hits complete in CMP (data and stall=0 in the cycle after
//   the request). Load misses refill a whole line from memory, word 0 first.
//   Stores go to memory as a single masked word write and are merged into the
//   line only when it is present.
// Ports
//   clk, rst : clock, synchronous active-high reset
//   bus      : riscv_dcache_ctrl_if.slave (CPU port + memory request/response port)
// Build option
//   DCACHE_WBUF_EN : adds a 1-entry write buffer so a store retires in CMP
//                    while its memory write drains in the background.
// Parameters
//   LINES, LINE_WORDS : powers of two, LINE_WORDS >= 2
//   ADDR_W            : significant byte-address bits; upper bits alias
module riscv_dcache_ctrl #(
   parameter int LINES      = 64,
   parameter int LINE_WORDS = 4,
   parameter int ADDR_W     = 28
) (
   input logic                clk,
   input logic                rst,
   riscv_dcache_ctrl_if.slave bus
);
   localparam int WORD_B = $clog2(LINE_WORDS);
   localparam int IDX_B  = $clog2(LINES);
   localparam int OFF_B  = WORD_B + 2;
   localparam int TAG_B  = ADDR_W - OFF_B - IDX_B;

   typedef enum logic [2:0] {IDLE, CMP, REFILL, WRITE, DONE} state_t;

   state_t                      state;
   logic [ADDR_W-3:0]           req_addr;   // word address, byte-offset bits dropped
   logic [3:0]                  req_we;
   logic [31:0]                 req_din;
   logic [WORD_B-1:0]           req_cnt;
   logic [WORD_B-1:0]           beat_cnt;
   logic                        stall_q;
   logic [31:0]                 dout_q;
   logic                        mreq_valid;
   logic [3:0]                  mreq_we;
   logic [31:0]                 mreq_addr;
   logic [31:0]                 mreq_data;
`ifdef DCACHE_WBUF_EN
   logic                        wb_valid;   // the mreq_* registers hold a pending store
`endif

   logic [31:0]                 data_arr [LINES*LINE_WORDS];
   logic [TAG_B-1:0]            tag_arr  [LINES];
   logic [LINES-1:0]            valid_arr;

   logic [IDX_B-1:0]            req_idx;
   logic [WORD_B-1:0]           req_word;
   logic [TAG_B-1:0]            req_tag;
   logic                        is_store;
   logic                        hit;
   logic                        cmp_stall;
   logic [31:0]                 line_base;
   logic [IDX_B+WORD_B-1:0]     cpu_widx;

   assign req_word  = req_addr[0 +: WORD_B];
   assign req_idx   = req_addr[OFF_B-2 +: IDX_B];
   assign req_tag   = req_addr[OFF_B-2+IDX_B +: TAG_B];
   assign is_store  = |req_we;   // re+we together is a store
   assign hit       = valid_arr[req_idx] && (tag_arr[req_idx] == req_tag);
   assign line_base = {{(32-ADDR_W){1'b0}}, req_addr[ADDR_W-3:OFF_B-2], {OFF_B{1'b0}}};
   assign cpu_widx  = {bus.cpu_addr[OFF_B +: IDX_B], bus.cpu_addr[2 +: WORD_B]};

   // The hit/miss decision is only known in CMP, so the stall for that one
   // cycle comes from the compare; every later stall cycle is registered.
`ifdef DCACHE_WBUF_EN
   assign cmp_stall = (state == CMP) && (is_store ? wb_valid : !hit);
`else
   assign cmp_stall = (state == CMP) && (is_store || !hit);
`endif

   assign bus.stall         = stall_q | cmp_stall;
   assign bus.cpu_dout      = dout_q;
   assign bus.mem_req_valid = mreq_valid;
   assign bus.mem_req_we    = mreq_we;
   assign bus.mem_req_addr  = mreq_addr;
   assign bus.mem_req_data  = mreq_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         req_addr   <= '0;
         req_we     <= '0;
         req_din    <= '0;
         req_cnt    <= '0;
         beat_cnt   <= '0;
         stall_q    <= 1'b0;
         dout_q     <= '0;
         mreq_valid <= 1'b0;
         mreq_we    <= '0;
         mreq_addr  <= '0;
         mreq_data  <= '0;
         valid_arr  <= '0;
`ifdef DCACHE_WBUF_EN
         wb_valid   <= 1'b0;
`endif
      end else begin
`ifdef DCACHE_WBUF_EN
         // Buffered store drains whenever the port is not busy with a refill;
         // a load miss never enters REFILL while the buffer is occupied.
         if (wb_valid && bus.mem_req_ready) begin
            wb_valid   <= 1'b0;
            mreq_valid <= 1'b0;
            mreq_we    <= '0;
         end
`endif
         case (state)
            IDLE: begin
               if (bus.cpu_re || (|bus.cpu_we)) begin
                  req_addr <= bus.cpu_addr[ADDR_W-1:2];
                  req_we   <= bus.cpu_we;
                  req_din  <= bus.cpu_din;
                  // Speculative read so a hit has its data ready in CMP.
                  dout_q   <= data_arr[cpu_widx];
                  state    <= CMP;
               end
            end
            CMP: begin
               if (is_store) begin
`ifdef DCACHE_WBUF_EN
                  if (!wb_valid) begin
                     wb_valid   <= 1'b1;
                     mreq_valid <= 1'b1;
                     mreq_we    <= req_we;
                     mreq_addr  <= {{(32-ADDR_W){1'b0}}, req_addr, 2'b00};
                     mreq_data  <= req_din;
                     state      <= IDLE;
                  end
`else
                  mreq_valid <= 1'b1;
                  mreq_we    <= req_we;
                  mreq_addr  <= {{(32-ADDR_W){1'b0}}, req_addr, 2'b00};
                  mreq_data  <= req_din;
                  stall_q    <= 1'b1;
                  state      <= WRITE;
`endif
               end else if (hit) begin
                  state <= IDLE;
               end else begin
`ifdef DCACHE_WBUF_EN
                  if (!wb_valid) begin
`else
                  begin
`endif
                     mreq_valid <= 1'b1;
                     mreq_we    <= '0;
                     mreq_addr  <= line_base;
                     req_cnt    <= '0;
                     beat_cnt   <= '0;
                     stall_q    <= 1'b1;
                     state      <= REFILL;
                  end
               end
            end
            REFILL: begin
               if (mreq_valid && bus.mem_req_ready) begin
                  req_cnt <= req_cnt + 1'b1;
                  if (req_cnt == WORD_B'(LINE_WORDS-1)) mreq_valid <= 1'b0;
                  else                                  mreq_addr  <= mreq_addr + 32'd4;
               end
               if (bus.mem_resp_valid) begin
                  if (beat_cnt == req_word) dout_q <= bus.mem_resp_data;
                  beat_cnt <= beat_cnt + 1'b1;
                  if (beat_cnt == WORD_B'(LINE_WORDS-1)) begin
                     valid_arr[req_idx] <= 1'b1;
                     stall_q            <= 1'b0;
                     state              <= DONE;
                  end
               end
            end
            WRITE: begin
               if (bus.mem_req_ready) begin
                  mreq_valid <= 1'b0;
                  mreq_we    <= '0;
                  stall_q    <= 1'b0;
                  state      <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Line storage has no reset; only the valid bits are cleared.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == CMP && is_store && hit) begin
            for (int b = 0; b < 4; b++)
               if (req_we[b]) data_arr[{req_idx, req_word}][8*b +: 8] <= req_din[8*b +: 8];
         end
         if (state == REFILL && bus.mem_resp_valid) begin
            data_arr[{req_idx, beat_cnt}] <= bus.mem_resp_data;
            if (beat_cnt == WORD_B'(LINE_WORDS-1)) tag_arr[req_idx] <= req_tag;
         end
      end
   end
endmodule

// File: tb/tb_riscv_dcache_ctrl.sv
`timescale 1ns/1ps
module tb_riscv_dcache_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   riscv_dcache_ctrl_if bus ();
   riscv_dcache_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef DCACHE_WBUF_EN
   localparam int STORE_LAT = 1;
`else
   localparam int STORE_LAT = 0;   // 0: must stall (latency > 1)
`endif

   typedef struct { bit is_load; logic [31:0] data; int lat; } cpu_exp_t;
   typedef struct { logic [31:0] addr; logic [3:0] we; logic [31:0] data; } mem_exp_t;
   typedef struct { logic [31:0] data; int due; } resp_t;

   cpu_exp_t cpu_q[$];
   mem_exp_t mem_q[$];
   resp_t    resp_q[$];
   logic [31:0] mem [logic [31:0]];

   int checks = 0, passed = 0;
   int cyc = 0, beats = 0;
   bit mem_hold = 0;

   task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : {16'hBEEF, a[15:0]};
   endfunction

   task automatic exp_wr(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
      mem_exp_t e;
      e.addr = a; e.we = we; e.data = d;
      mem_q.push_back(e);
   endtask

   task automatic exp_line(input logic [31:0] base);
      for (int k = 0; k < 4; k++) exp_wr(base + 32'(4*k), 4'h0, 32'h0);
   endtask

   // Memory model and memory-side monitor: ready/resp are decided at the
   // negedge for the following posedge, so the handshake seen here is exactly
   // the one the DUT will see.
   bit          prev_stuck = 0;
   logic [68:0] prev_req;
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         resp_q.delete();
         mem_q.delete();
         bus.mem_resp_valid = 1'b0;
         bus.mem_req_ready  = 1'b0;
         prev_stuck = 0;
      end else begin
         if (prev_stuck)
            check("mem_req_hold", {bus.mem_req_valid, bus.mem_req_we, bus.mem_req_addr, bus.mem_req_data}, prev_req);
         if (resp_q.size() != 0 && resp_q[0].due <= cyc) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = resp_q[0].data;
            void'(resp_q.pop_front());
            beats++;
         end else begin
            bus.mem_resp_valid = 1'b0;
         end
         bus.mem_req_ready = !mem_hold && (cyc % 3 != 1);
         if (bus.mem_req_valid && bus.mem_req_ready) begin
            check("mem_req_expected", mem_q.size() != 0, 1);
            if (mem_q.size() != 0) begin
               mem_exp_t e;
               e = mem_q.pop_front();
               check("mem_addr", bus.mem_req_addr, e.addr);
               check("mem_we", bus.mem_req_we, e.we);
               if (e.we != 0) check("mem_wdata", bus.mem_req_data, e.data);
            end
            if (bus.mem_req_we != 0) begin
               logic [31:0] w;
               w = mem_rd(bus.mem_req_addr);
               for (int b = 0; b < 4; b++)
                  if (bus.mem_req_we[b]) w[8*b +: 8] = bus.mem_req_data[8*b +: 8];
               mem[bus.mem_req_addr] = w;
            end else begin
               resp_t r;
               r.data = mem_rd(bus.mem_req_addr);
               r.due  = cyc + 2;
               resp_q.push_back(r);
            end
         end
         prev_stuck = bus.mem_req_valid && !bus.mem_req_ready;
         prev_req   = {bus.mem_req_valid, bus.mem_req_we, bus.mem_req_addr, bus.mem_req_data};
      end
   end

   // CPU-side monitor: a request is taken at the posedge when nothing is
   // outstanding; it completes at the first later negedge with stall low.
   bit pend = 0, pend_load = 0;
   int lat = 0;
   always @(posedge clk) begin
      if (rst) pend = 0;
      else if (!pend && (bus.cpu_re || bus.cpu_we != 4'h0)) begin
         pend = 1; pend_load = (bus.cpu_we == 4'h0); lat = 0;
      end
   end
   always @(negedge clk) begin
      if (pend && !rst) begin
         lat++;
         if (!bus.stall) begin
            pend = 0;
            check("cpu_resp_expected", cpu_q.size() != 0, 1);
            if (cpu_q.size() != 0) begin
               cpu_exp_t e;
               e = cpu_q.pop_front();
               check("op_kind", pend_load, e.is_load);
               if (e.is_load) check("load_data", bus.cpu_dout, e.data);
               if (e.lat == 1) check("one_cycle_latency", lat, 1);
               else            check("stalled", lat > 1, 1);
            end
         end
      end
   end

   task automatic finish_now();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   endtask

   task automatic cpu_op(input logic [31:0] a, input bit re, input logic [3:0] we,
                         input logic [31:0] d, input logic [31:0] exp, input int elat);
      cpu_exp_t e;
      int n;
      e.is_load = (we == 4'h0); e.data = exp; e.lat = elat;
      cpu_q.push_back(e);
      @(negedge clk);
      bus.cpu_addr = a; bus.cpu_re = re; bus.cpu_we = we; bus.cpu_din = d;
      @(posedge clk);
      n = 0;
      do begin @(negedge clk); n++; end while (bus.stall && n < 300);
      if (bus.stall) begin
         check("cpu_op_timeout", 1'b1, 1'b0);
         finish_now();
      end
      bus.cpu_re = 1'b0; bus.cpu_we = 4'h0;
   endtask

   initial begin
      int n, b0;
      bus.cpu_addr = 0; bus.cpu_re = 0; bus.cpu_we = 0; bus.cpu_din = 0;
      bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_resp_data = 0;
      mem[32'h104] = 32'h11223344;
      repeat (3) @(negedge clk);
      check("rst_stall", bus.stall, 0);
      check("rst_mem_valid", bus.mem_req_valid, 0);
      check("rst_mem_we", bus.mem_req_we, 0);
      check("rst_dout", bus.cpu_dout, 0);
      rst = 0;

      // cold miss, then hit in the same line
      exp_line(32'h100);
      cpu_op(32'h100, 1, 4'h0, 0, 32'hBEEF0100, 0);
      cpu_op(32'h104, 1, 4'h0, 0, 32'h11223344, 1);
      // store hit: byte merge into line and masked write to memory
      exp_wr(32'h104, 4'b0011, 32'hAABBCCDD);
      cpu_op(32'h104, 0, 4'b0011, 32'hAABBCCDD, 0, STORE_LAT);
      cpu_op(32'h104, 1, 4'h0, 0, 32'h1122CCDD, 1);
      // store miss: no allocate, later load refills from updated memory
      exp_wr(32'h2000, 4'hF, 32'h12345678);
      cpu_op(32'h2000, 0, 4'hF, 32'h12345678, 0, STORE_LAT);
      exp_line(32'h2000);
      cpu_op(32'h2000, 1, 4'h0, 0, 32'h12345678, 0);
      // upper address bits alias onto the same line
      cpu_op(32'hF000_0104, 1, 4'h0, 0, 32'h1122CCDD, 1);
      // re and we together behave as a store
      exp_wr(32'h108, 4'hF, 32'h0BADF00D);
      cpu_op(32'h108, 1, 4'hF, 32'h0BADF00D, 0, STORE_LAT);
      cpu_op(32'h108, 1, 4'h0, 0, 32'h0BADF00D, 1);
      // conflict eviction on index 16
      cpu_op(32'h100, 1, 4'h0, 0, 32'hBEEF0100, 1);
      exp_line(32'h500);
      cpu_op(32'h500, 1, 4'h0, 0, 32'hBEEF0500, 0);
      cpu_op(32'h50C, 1, 4'h0, 0, 32'hBEEF050C, 1);
      exp_line(32'h100);
      cpu_op(32'h10C, 1, 4'h0, 0, 32'hBEEF010C, 0);
      cpu_op(32'h108, 1, 4'h0, 0, 32'h0BADF00D, 1);
      cpu_op(32'h104, 1, 4'h0, 0, 32'h1122CCDD, 1);

      // reset while the third beat of a refill is pending
      exp_line(32'h300);
      b0 = beats;
      @(negedge clk);
      bus.cpu_addr = 32'h300; bus.cpu_re = 1;
      n = 0;
      while (beats < b0 + 2 && n < 200) begin @(negedge clk); n++; end
      check("refill_beats_seen", beats >= b0 + 2, 1);
      @(negedge clk);
      rst = 1; bus.cpu_re = 0;
      @(negedge clk);
      check("midrst_stall", bus.stall, 0);
      check("midrst_mem_valid", bus.mem_req_valid, 0);
      @(negedge clk);
      rst = 0;
      @(negedge clk);
      exp_line(32'h100);
      cpu_op(32'h100, 1, 4'h0, 0, 32'hBEEF0100, 0);
      exp_line(32'h300);
      cpu_op(32'h300, 1, 4'h0, 0, 32'hBEEF0300, 0);

`ifdef DCACHE_WBUF_EN
      // back-to-back stores with memory stalled: only the second one waits
      mem_hold = 1;
      exp_wr(32'h400, 4'hF, 32'h44444444);
      exp_wr(32'h404, 4'hF, 32'h55555555);
      cpu_op(32'h400, 0, 4'hF, 32'h44444444, 0, 1);
      fork
         cpu_op(32'h404, 0, 4'hF, 32'h55555555, 0, 0);
         begin repeat (8) @(negedge clk); mem_hold = 0; end
      join
`endif

      repeat (20) @(negedge clk);
      check("cpu_q_drained", cpu_q.size(), 0);
      check("mem_q_drained", mem_q.size(), 0);
      finish_now();
   end
endmodule
